// File: rtl/input_event_aligner.sv
// input_event_aligner
// Buffers input-stream events arriving on any cycle and hands them to the
// RTLola monitor one per HLC period, so that new_input is high exactly in
// the cycle where the monitor's llc_stage is 0.
module input_event_aligner #(
  parameter int DATA_WIDTH = 64,
  parameter int DEPTH      = 4,
  parameter int NUM_STAGES = 4
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                en,
  input  logic signed [DATA_WIDTH-1:0]        in_data,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic signed [63:0]                  llc_stage,
  output logic signed [DATA_WIDTH-1:0]        input_a,
  output logic                                new_input,
  output logic        [$clog2(DEPTH+1)-1:0]   count,
  output logic                                overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH + 1);

  localparam logic        [CNT_W-1:0] FULL_COUNT    = CNT_W'(DEPTH);
  localparam logic signed [63:0]      RELEASE_STAGE = 64'(NUM_STAGES - 1);

  logic signed [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic        [PTR_W-1:0]      r_wrPtr;
  logic        [PTR_W-1:0]      r_rdPtr;
  logic        [CNT_W-1:0]      r_count;
  logic                         r_overflow;
  logic signed [DATA_WIDTH-1:0] r_inputA;
  logic                         r_newInput;

  logic w_notFull;
  logic w_push;
  logic w_drop;
  logic w_pop;

  // Acceptance looks only at registered occupancy, so a full FIFO refuses
  // an event even in the cycle it releases one.
  assign w_notFull = (r_count != FULL_COUNT);
  assign w_push    = in_valid && w_notFull;
  assign w_drop    = in_valid && !w_notFull;

  // Release on the last LLC stage so the registered strobe lands on stage 0;
  // stage values outside the legal range simply never match.
  assign w_pop = en && (r_count != '0) && (llc_stage == RELEASE_STAGE);

  // Storage array; contents need no reset because occupancy gates every read.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wrPtr] <= in_data;
    end
  end

  // Read/write pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_push) begin
        r_wrPtr <= r_wrPtr + PTR_W'(1);
      end
      if (w_pop) begin
        r_rdPtr <= r_rdPtr + PTR_W'(1);
      end
    end
  end

  // Occupancy counter; a simultaneous push and pop leaves it unchanged.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_count <= '0;
    end else begin
      unique case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Sticky overflow flag, cleared only by reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end
  end

  // Output stage: the head is captured on release, otherwise the value holds
  // and the strobe drops; the head read never sees this edge's push.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_inputA   <= '0;
      r_newInput <= 1'b0;
    end else if (w_pop) begin
      r_inputA   <= r_mem[r_rdPtr];
      r_newInput <= 1'b1;
    end else begin
      r_newInput <= 1'b0;
    end
  end

  assign in_ready  = w_notFull;
  assign input_a   = r_inputA;
  assign new_input = r_newInput;
  assign count     = r_count;
  assign overflow  = r_overflow;

endmodule

// File: tb/tb_input_event_aligner.sv
// Directed testbench for input_event_aligner. The bench owns a free-running
// LLC stage counter (0..3) and drives llc_stage from it, like the monitor.
module tb_input_event_aligner;

  logic               clk;
  logic               rst;
  logic               en;
  logic signed [63:0] in_data;
  logic               in_valid;
  logic               in_ready;
  logic signed [63:0] llc_stage;
  logic signed [63:0] input_a;
  logic               new_input;
  logic [2:0]         count;
  logic               overflow;

  int                 vecCount;
  int                 missCount;
  int                 stage;
  logic               bogusMode;
  logic signed [63:0] bogusVal;

  input_event_aligner #(
    .DATA_WIDTH(64),
    .DEPTH(4),
    .NUM_STAGES(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .en(en),
    .in_data(in_data),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .llc_stage(llc_stage),
    .input_a(input_a),
    .new_input(new_input),
    .count(count),
    .overflow(overflow)
  );

  // Free-running clock, 10 time units per period.
  always #5 clk = ~clk;

  // One clock edge; outputs are sampled 1 unit later and the stage advances.
  task automatic tick();
    @(posedge clk);
    #1;
    stage = (stage + 1) % 4;
    llc_stage = bogusMode ? bogusVal : 64'(stage);
  endtask

  // Advance until the stage presented at the next edge equals s (<= 3 ticks).
  task automatic waitStage(input int s);
    for (int i = 0; i < 4 && stage != s; i++) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    vecCount++; if (count !== 3'd0) begin missCount++; $display("[TB] FAIL reset_count: got %0d expected 0", count); end
    vecCount++; if (in_ready !== 1'b1) begin missCount++; $display("[TB] FAIL reset_in_ready: got %0b expected 1", in_ready); end
    vecCount++; if (new_input !== 1'b0) begin missCount++; $display("[TB] FAIL reset_new_input: got %0b expected 0", new_input); end
    vecCount++; if (input_a !== 64'sd0) begin missCount++; $display("[TB] FAIL reset_input_a: got %0d expected 0", input_a); end
    vecCount++; if (overflow !== 1'b0) begin missCount++; $display("[TB] FAIL reset_overflow: got %0b expected 0", overflow); end
    for (int t = 0; t < 20; t++) begin
      tick();
      vecCount++; if (new_input !== 1'b0) begin missCount++; $display("[TB] FAIL idle_new_input t=%0d: got %0b expected 0", t, new_input); end
      vecCount++; if (input_a !== 64'sd0) begin missCount++; $display("[TB] FAIL idle_input_a t=%0d: got %0d expected 0", t, input_a); end
      vecCount++; if (count !== 3'd0) begin missCount++; $display("[TB] FAIL idle_count t=%0d: got %0d expected 0", t, count); end
      vecCount++; if (in_ready !== 1'b1) begin missCount++; $display("[TB] FAIL idle_in_ready t=%0d: got %0b expected 1", t, in_ready); end
    end
  endtask

  task automatic test_single();
    waitStage(1);
    in_valid = 1'b1;
    in_data  = 64'sd7;
    tick();
    in_valid = 1'b0;
    vecCount++; if (count !== 3'd1) begin missCount++; $display("[TB] FAIL single_count_after_push: got %0d expected 1", count); end
    for (int t = 1; t <= 3; t++) begin
      tick();
      vecCount++; if (new_input !== (t == 2)) begin missCount++; $display("[TB] FAIL single_strobe t=%0d: got %0b expected %0b", t, new_input, (t == 2)); end
      if (t >= 2) begin
        vecCount++; if (input_a !== 64'sd7) begin missCount++; $display("[TB] FAIL single_input_a t=%0d: got %0d expected 7", t, input_a); end
        vecCount++; if (count !== 3'd0) begin missCount++; $display("[TB] FAIL single_count t=%0d: got %0d expected 0", t, count); end
      end
    end
  endtask

  task automatic test_burst();
    waitStage(3);
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1;
      in_data  = 64'(i + 1);
      tick();
      vecCount++; if (new_input !== 1'b0) begin missCount++; $display("[TB] FAIL burst_no_bypass i=%0d: got %0b expected 0", i, new_input); end
    end
    in_valid = 1'b0;
    vecCount++; if (count !== 3'd4) begin missCount++; $display("[TB] FAIL burst_full_count: got %0d expected 4", count); end
    vecCount++; if (in_ready !== 1'b0) begin missCount++; $display("[TB] FAIL burst_full_in_ready: got %0b expected 0", in_ready); end
    for (int t = 5; t <= 20; t++) begin
      tick();
      vecCount++; if (new_input !== ((t - 5) % 4 == 0)) begin missCount++; $display("[TB] FAIL burst_strobe t=%0d: got %0b expected %0b", t, new_input, ((t - 5) % 4 == 0)); end
      vecCount++; if (input_a !== 64'((t - 5) / 4 + 1)) begin missCount++; $display("[TB] FAIL burst_input_a t=%0d: got %0d expected %0d", t, input_a, (t - 5) / 4 + 1); end
    end
    vecCount++; if (count !== 3'd0) begin missCount++; $display("[TB] FAIL burst_drained_count: got %0d expected 0", count); end
  endtask

  task automatic test_overflow();
    en = 1'b0;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1;
      in_data  = 64'(10 + i);
      tick();
    end
    in_valid = 1'b0;
    vecCount++; if (count !== 3'd4) begin missCount++; $display("[TB] FAIL ovf_count: got %0d expected 4", count); end
    vecCount++; if (overflow !== 1'b1) begin missCount++; $display("[TB] FAIL ovf_flag: got %0b expected 1", overflow); end
    vecCount++; if (in_ready !== 1'b0) begin missCount++; $display("[TB] FAIL ovf_in_ready: got %0b expected 0", in_ready); end
    vecCount++; if (new_input !== 1'b0) begin missCount++; $display("[TB] FAIL ovf_en_low_strobe: got %0b expected 0", new_input); end
    waitStage(0);
    en = 1'b1;
    for (int t = 1; t <= 16; t++) begin
      tick();
      vecCount++; if (new_input !== (t % 4 == 0)) begin missCount++; $display("[TB] FAIL ovf_strobe t=%0d: got %0b expected %0b", t, new_input, (t % 4 == 0)); end
      vecCount++; if (input_a !== ((t < 4) ? 64'sd4 : 64'(9 + t / 4))) begin missCount++; $display("[TB] FAIL ovf_input_a t=%0d: got %0d expected %0d", t, input_a, (t < 4) ? 4 : (9 + t / 4)); end
    end
    vecCount++; if (overflow !== 1'b1) begin missCount++; $display("[TB] FAIL ovf_sticky: got %0b expected 1", overflow); end
    vecCount++; if (count !== 3'd0) begin missCount++; $display("[TB] FAIL ovf_drained_count: got %0d expected 0", count); end
  endtask

  task automatic test_simultaneous();
    waitStage(0);
    in_valid = 1'b1;
    in_data  = 64'sd20;
    tick();
    in_data  = 64'sd21;
    tick();
    in_valid = 1'b0;
    tick();
    vecCount++; if (count !== 3'd2) begin missCount++; $display("[TB] FAIL simul_pre_count: got %0d expected 2", count); end
    in_valid = 1'b1;
    in_data  = 64'sd9;
    tick();
    in_valid = 1'b0;
    vecCount++; if (new_input !== 1'b1) begin missCount++; $display("[TB] FAIL simul_strobe: got %0b expected 1", new_input); end
    vecCount++; if (input_a !== 64'sd20) begin missCount++; $display("[TB] FAIL simul_input_a: got %0d expected 20", input_a); end
    vecCount++; if (count !== 3'd2) begin missCount++; $display("[TB] FAIL simul_count: got %0d expected 2", count); end
    for (int t = 1; t <= 8; t++) begin
      tick();
      vecCount++; if (new_input !== (t % 4 == 0)) begin missCount++; $display("[TB] FAIL simul_later_strobe t=%0d: got %0b expected %0b", t, new_input, (t % 4 == 0)); end
      vecCount++; if (input_a !== ((t < 4) ? 64'sd20 : (t < 8) ? 64'sd21 : 64'sd9)) begin missCount++; $display("[TB] FAIL simul_later_input_a t=%0d: got %0d expected %0d", t, input_a, (t < 4) ? 20 : (t < 8) ? 21 : 9); end
    end
    vecCount++; if (count !== 3'd0) begin missCount++; $display("[TB] FAIL simul_drained_count: got %0d expected 0", count); end
  endtask

  task automatic test_out_of_range();
    int strobes;
    logic signed [63:0] lastA;
    bogusMode = 1'b1;
    bogusVal  = 64'sd7;
    llc_stage = bogusVal;
    in_valid  = 1'b1;
    in_data   = 64'sd50;
    tick();
    in_valid = 1'b0;
    for (int t = 1; t <= 8; t++) begin
      bogusVal = (t % 3 == 0) ? 64'sd4 : (t % 3 == 1) ? -64'sd1 : 64'sd7;
      tick();
      vecCount++; if (new_input !== 1'b0) begin missCount++; $display("[TB] FAIL oor_strobe t=%0d: got %0b expected 0", t, new_input); end
    end
    vecCount++; if (count !== 3'd1) begin missCount++; $display("[TB] FAIL oor_count: got %0d expected 1", count); end
    bogusMode = 1'b0;
    llc_stage = 64'(stage);
    strobes = 0;
    lastA = '0;
    for (int t = 1; t <= 4; t++) begin
      tick();
      if (new_input === 1'b1) begin
        strobes++;
        lastA = input_a;
      end
    end
    vecCount++; if (strobes != 1) begin missCount++; $display("[TB] FAIL oor_resume_strobes: got %0d expected 1", strobes); end
    vecCount++; if (lastA !== 64'sd50) begin missCount++; $display("[TB] FAIL oor_resume_value: got %0d expected 50", lastA); end
  endtask

  task automatic test_reset_mid();
    waitStage(0);
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1;
      in_data  = 64'(30 + i);
      tick();
    end
    in_valid = 1'b0;
    vecCount++; if (count !== 3'd3) begin missCount++; $display("[TB] FAIL rstmid_pre_count: got %0d expected 3", count); end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    vecCount++; if (new_input !== 1'b0) begin missCount++; $display("[TB] FAIL rstmid_strobe: got %0b expected 0", new_input); end
    vecCount++; if (count !== 3'd0) begin missCount++; $display("[TB] FAIL rstmid_count: got %0d expected 0", count); end
    vecCount++; if (input_a !== 64'sd0) begin missCount++; $display("[TB] FAIL rstmid_input_a: got %0d expected 0", input_a); end
    vecCount++; if (in_ready !== 1'b1) begin missCount++; $display("[TB] FAIL rstmid_in_ready: got %0b expected 1", in_ready); end
    vecCount++; if (overflow !== 1'b0) begin missCount++; $display("[TB] FAIL rstmid_overflow: got %0b expected 0", overflow); end
    for (int t = 1; t <= 8; t++) begin
      tick();
      vecCount++; if (new_input !== 1'b0) begin missCount++; $display("[TB] FAIL rstmid_after_strobe t=%0d: got %0b expected 0", t, new_input); end
      vecCount++; if (count !== 3'd0) begin missCount++; $display("[TB] FAIL rstmid_after_count t=%0d: got %0d expected 0", t, count); end
    end
  endtask

  // Run every scenario in order, then report.
  initial begin
    clk       = 1'b0;
    rst       = 1'b1;
    en        = 1'b1;
    in_data   = '0;
    in_valid  = 1'b0;
    stage     = 0;
    llc_stage = '0;
    bogusMode = 1'b0;
    bogusVal  = '0;
    vecCount  = 0;
    missCount = 0;

    test_reset();
    test_single();
    test_burst();
    test_overflow();
    test_simultaneous();
    test_out_of_range();
    test_reset_mid();

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/input_event_aligner.md
# input_event_aligner

Upstream feeder for the RTLola monitor's `topEntity`. Accepts input-stream events (value + valid) on any clock cycle and buffers them in a small FIFO. Releases at most one event per HLC period, presented so that `new_input` is high exactly during the cycle in which the monitor's `llc_stage` is 0. This removes the requirement that producers align new data to stage 0 themselves.

## Interface
Parameters:
- `DATA_WIDTH`, 64, width of the input-stream value (signed).
- `DEPTH`, 4, FIFO entries; power of two, ≥2.
- `NUM_STAGES`, 4, LLC stages per HLC period; stage counts `0..NUM_STAGES-1`.

Ports (one clock; reset is synchronous and active-high):
- `clk`  in  1  — system clock, shared with the monitor.
- `rst`  in  1  — synchronous, active-high reset.
- `en`  in  1  — release enable, tied to the monitor's `en`.
- `in_data`  in  DATA_WIDTH  — event value, signed.
- `in_valid`  in  1  — event present this cycle.
- `in_ready`  out  1  — FIFO not full; event accepted iff `in_valid && in_ready` at the edge.
- `llc_stage`  in  64  — monitor's current LLC stage, signed.
- `input_a`  out  DATA_WIDTH  — value to the monitor; holds the last released value.
- `new_input`  out  1  — release strobe to the monitor.
- `count`  out  $clog2(DEPTH+1)  — current occupancy.
- `overflow`  out  1  — sticky; set when an event is offered while full.

## Operation
- FIFO: circular buffer with read/write pointers of `$clog2(DEPTH)` bits, wrapping modulo `DEPTH`, plus a separate occupancy counter.
- **Push:** when `in_valid && in_ready`, write to the write pointer and advance it.
  - When `in_valid && !in_ready`, drop the event and set `overflow`.
- **Release (pop) condition,** evaluated on registered state at each edge: `en && count != 0 && llc_stage == NUM_STAGES-1`.
  - On release, register `input_a <= head`, `new_input <= 1`, and advance the read pointer.
  - Otherwise `new_input <= 0` and `input_a` holds its value.
- Releases are therefore at most one per HLC period. `new_input` is high for exactly the one cycle where `llc_stage == 0`.
- **Simultaneous push and pop:** both occur; `count` is unchanged.
- **No bypass:** an event pushed at the same edge as a release decision is not the one released.
- `in_ready = (count != DEPTH)`. This is based on registered `count` only, so a push while full is rejected even if a pop happens in the same cycle.
- `en` low:
  - no releases; `new_input` is 0;
  - queued events are retained;
  - pushes are still accepted.
- `llc_stage` values outside `0..NUM_STAGES-1` never trigger a release.
- `overflow` clears only on reset.

## Timing
- Reset values:
  - `count` = 0;
  - both pointers = 0;
  - `input_a` = 0;
  - `new_input` = 0;
  - `overflow` = 0;
  - `in_ready` = 1.
- Reset mid-operation discards all queued events. `new_input` is 0 in the cycle after the reset edge, even if a release was due.
- **Latency:** an event accepted at edge k is released at the first edge e > k where `llc_stage == NUM_STAGES-1`. It is visible on `input_a`/`new_input` from e until the next edge.
  - Best case: 1 cycle from push to strobe.
  - Worst case, from an empty FIFO: `NUM_STAGES` cycles.
- **Queued events:** the n-th queued event (1-based, FIFO order) is strobed n−1 HLC periods after the first, i.e. spaced exactly `NUM_STAGES` cycles apart.
- `count` and `in_ready` update at the edge after a push or pop; there are no combinational paths from `in_valid` to `in_ready`.
- `input_a` changes only on cycles when `new_input` rises.

## Test plan
- Reset then idle: 20 cycles with no input, stage cycling 0..3 → `new_input` is never 1, `input_a` = 0, `count` = 0, `in_ready` = 1.
- Single event: push `in_data` = 7 while `llc_stage` = 1 → `new_input` = 1 and `input_a` = 7 during the next stage-0 cycle only; `count` returns to 0.
- Burst: push 1, 2, 3, 4 on four consecutive cycles → strobes carry 1, 2, 3, 4 on four successive stage-0 cycles, 4 cycles apart; `in_ready` = 0 while `count` = 4.
- Overflow: with `en` = 0, push 5 events (values 10..14) → first 4 queued, value 14 dropped, `overflow` = 1. Then set `en` = 1 → values 10..13 are released in order and `overflow` stays 1.
- Simultaneous push and pop: `count` = 2, push 9 on the `llc_stage` = 3 cycle → head is released, `count` stays 2, and 9 is released two periods later.
- Reset mid-queue: 3 events queued, assert `rst` on a stage-3 cycle → no strobe follows; `count` = 0 and `input_a` = 0.
